mem_arbiter: RTL

Two-port request/grant arbiter that shares one single-port synchronous block RAM between two requesters: port 0 is the Hack CPU data-memory interface and port 1 is the UART program loader / screen scanout reader. At most one access is issued to the RAM per cycle. Read data returns to the requester that issued it after a fixed RAM latency. Sits between the requesters and the on-chip BRAM wrapper in the top level.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port request/grant arbiter sharing one single-port
//               synchronous RAM, with tagged read-data return.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int c_LAST = RD_LATENCY - 1;

    logic                  r_last_gnt;
    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [RD_LATENCY-1:0] r_tag_port;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if ((FIXED_PRIO != 0) || r_last_gnt) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_we    = we0;
            w_mem_addr  = addr0;
            w_mem_wdata = wdata0;
        end else if (w_gnt1) begin
            w_mem_we    = we1;
            w_mem_addr  = addr1;
            w_mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0) begin
            r_last_gnt <= 1'b0;
        end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
        end
    end

    // Each stage carries {valid, port}; only granted reads enter as valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld[0]  <= (w_gnt0 | w_gnt1) & ~w_mem_we;
            r_tag_port[0] <= w_gnt1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign mem_en    = w_gnt0 | w_gnt1;
    assign mem_we    = w_mem_we;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;

    assign rvalid0   = r_tag_vld[c_LAST] & ~r_tag_port[c_LAST];
    assign rvalid1   = r_tag_vld[c_LAST] &  r_tag_port[c_LAST];
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;

endmodule
`default_nettype wire
